// File: rtl/sobel_pkg.sv
// Constants and line types shared across the Sobel datapath.
// Includes the rounding step of the RGB-to-luma conversion.
package sobel_pkg;

    localparam int PIXEL_W = 8;
    localparam int RGBA_W  = 32;

    localparam logic [7:0]  LUMA_R     = 8'd77;
    localparam logic [7:0]  LUMA_G     = 8'd150;
    localparam logic [7:0]  LUMA_B     = 8'd29;
    localparam logic [15:0] LUMA_ROUND = 16'd128;

    typedef logic [127:0] gray_line_t;
    typedef logic [511:0] rgba_line_t;

    // Peak sum is 65408, so a 16-bit accumulator never wraps.
    function automatic logic [PIXEL_W-1:0] luma_round(
        input logic [15:0] p_r,
        input logic [15:0] p_g,
        input logic [15:0] p_b
    );
        logic [15:0] sum;
        sum = p_r + p_g + p_b + LUMA_ROUND;
        return sum[15:8];
    endfunction

endpackage

// File: rtl/rgba_to_gray_unit_fifo.sv
// Synchronous FIFO with the head entry driven from storage registers and an
// occupancy count. Push into a full FIFO is accepted only alongside a pop.
module gray_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rgba_to_gray_unit.sv
// Converts lines of RGBA pixels to packed 8-bit luma through a two-stage
// pipeline feeding a credit-protected output FIFO.
module rgba_to_gray_unit
    import sobel_pkg::*;
#(
    parameter int PARALLEL_UNITS = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid_in,
    output logic                                o_ready_in,
    input  logic [RGBA_W*PARALLEL_UNITS-1:0]    i_data_in,
    output logic                                o_valid_out,
    input  logic                                i_ready_out,
    output logic [PIXEL_W*PARALLEL_UNITS-1:0]   o_data_out,
    output logic                                o_busy
);
    localparam int OUT_W = PIXEL_W * PARALLEL_UNITS;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 3);

    if (FIFO_DEPTH < 4) begin : g_bad_depth
        $error("rgba_to_gray_unit: FIFO_DEPTH must be at least 4");
    end

    logic              r_s1_valid;
    logic [15:0]       r_s1_prod_r [PARALLEL_UNITS];
    logic [15:0]       r_s1_prod_g [PARALLEL_UNITS];
    logic [15:0]       r_s1_prod_b [PARALLEL_UNITS];
    logic              r_s2_valid;
    logic [OUT_W-1:0]  r_s2_gray;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [OUT_W-1:0]  w_fifo_head;
    logic [OCC_W-1:0]  w_occ;
    logic              w_accept;
    logic              w_pop;
    logic              w_unused_alpha;

    // Credits cover every line between acceptance and the downstream pop.
    assign w_occ = OCC_W'(w_fifo_count) + OCC_W'(r_s1_valid) + OCC_W'(r_s2_valid);

    assign o_ready_in  = !i_rst && (w_occ < OCC_W'(FIFO_DEPTH));
    assign o_valid_out = !i_rst && (w_fifo_count != '0);
    assign o_data_out  = w_fifo_head;
    assign o_busy      = (w_occ != '0);
    assign w_accept    = i_valid_in && o_ready_in;
    assign w_pop       = o_valid_out && i_ready_out;

    always_comb begin
        w_unused_alpha = 1'b0;
        for (int i = 0; i < PARALLEL_UNITS; i++) begin
            w_unused_alpha = w_unused_alpha ^ (^i_data_in[RGBA_W*i+24 +: 8]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int i = 0; i < PARALLEL_UNITS; i++) begin
                r_s1_prod_r[i] <= 16'(i_data_in[RGBA_W*i      +: 8]) * 16'(LUMA_R);
                r_s1_prod_g[i] <= 16'(i_data_in[RGBA_W*i + 8  +: 8]) * 16'(LUMA_G);
                r_s1_prod_b[i] <= 16'(i_data_in[RGBA_W*i + 16 +: 8]) * 16'(LUMA_B);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_s1_valid) begin
            for (int i = 0; i < PARALLEL_UNITS; i++) begin
                r_s2_gray[PIXEL_W*i +: PIXEL_W] <=
                    luma_round(r_s1_prod_r[i], r_s1_prod_g[i], r_s1_prod_b[i]);
            end
        end
    end

    gray_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_gray_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_s2_valid),
        .i_data  (r_s2_gray),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_rgba_to_gray_unit.sv
// Self-checking bench for rgba_to_gray_unit: table vectors, directed corner
// sequences and randomized traffic against a queue-based luma model.
module tb_rgba_to_gray_unit;
    import sobel_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready_in;
    rgba_line_t data_in;
    logic       valid_out;
    logic       ready_out;
    gray_line_t data_out;
    logic       busy;

    always #5 clk = ~clk;

    rgba_to_gray_unit #(
        .PARALLEL_UNITS (16),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid_in  (valid_in),
        .o_ready_in  (ready_in),
        .i_data_in   (data_in),
        .o_valid_out (valid_out),
        .i_ready_out (ready_out),
        .o_data_out  (data_out),
        .o_busy      (busy)
    );

    typedef struct {
        logic [31:0] pix;
        logic [7:0]  gray;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    gray_line_t exp_q[$];
    rgba_line_t tx_q[$];
    bit         rnd_valid = 0;
    bit         rnd_ready = 0;
    bit         ready_lvl = 0;
    bit         s_acc = 0;
    bit         s_pop = 0;
    bit         s_vo = 0;
    bit         holding = 0;
    gray_line_t s_pop_data;
    bit         stall_prev = 0;
    gray_line_t stall_data;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         out_cnt = 0;

    // Reference luma, straight from the arithmetic definition.
    function automatic gray_line_t model(input rgba_line_t line);
        gray_line_t g;
        for (int i = 0; i < 16; i++) begin
            int r, gg, b, y;
            r  = int'(line[32*i      +: 8]);
            gg = int'(line[32*i + 8  +: 8]);
            b  = int'(line[32*i + 16 +: 8]);
            y  = (77*r + 150*gg + 29*b + 128) / 256;
            g[8*i +: 8] = 8'(y);
        end
        return g;
    endfunction

    function automatic rgba_line_t rand_line();
        rgba_line_t l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input gray_line_t act, input gray_line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        if (!holding) begin
            if (tx_q.size() > 0 && (!rnd_valid || $urandom_range(1) == 1)) begin
                valid_in = 1'b1;
                data_in  = tx_q[0];
            end else begin
                valid_in = 1'b0;
            end
        end
        ready_out = rnd_ready ? ($urandom_range(1) == 1) : ready_lvl;
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        s_acc      = valid_in && ready_in;
        s_pop      = valid_out && ready_out;
        s_vo       = valid_out;
        s_pop_data = data_out;
        holding    = valid_in && !s_acc;
        if (rst) begin
            chk1("ready_in_during_reset", ready_in, 1'b0);
            chk1("valid_out_during_reset", valid_out, 1'b0);
            exp_q.delete();
            stall_prev = 0;
            s_acc = 0;
            s_pop = 0;
        end else begin
            chk1("ready_in_credit", ready_in, exp_q.size() < 4);
            chk1("busy_inflight", busy, exp_q.size() != 0);
            if (stall_prev) begin
                chk1("stall_valid_held", valid_out, 1'b1);
                chkw("stall_data_held", data_out, stall_data);
            end
            stall_prev = valid_out && !ready_out;
            stall_data = data_out;
            if (s_pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got %h expected no line (cycle %0d)", data_out, cyc);
                end else begin
                    chkw("scoreboard_line", data_out, exp_q.pop_front());
                end
                out_cnt++;
            end
            if (s_acc) begin
                exp_q.push_back(model(data_in));
                acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (s_acc) void'(tx_q.pop_front());
        apply();
    endtask

    task automatic run_until_out(input int target, input int budget, input string name);
        int n = 0;
        while (out_cnt < target && n < budget) begin
            step();
            n++;
        end
        if (out_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d outputs expected %0d", name, out_cnt, target);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[5];
        rgba_line_t line;
        int         n, lat, base, obase, first_acc, first_out, bubbles, in_stalls, tgt;

        vecs[0] = '{32'h00FFFFFF, 8'hFF};
        vecs[1] = '{32'h000000FF, 8'h4D};
        vecs[2] = '{32'h0000FF00, 8'h95};
        vecs[3] = '{32'h00FF0000, 8'h1D};
        vecs[4] = '{32'hFF808080, 8'h80};

        rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk1("reset_ready_in", ready_in, 1'b1);
        chk1("reset_valid_out", valid_out, 1'b0);
        chkw("reset_data_out", data_out, '0);
        chk1("reset_busy", busy, 1'b0);

        // Colour primaries, one solid line each.
        ready_lvl = 1; apply();
        for (int i = 0; i < 5; i++) begin
            tx_q.push_back({16{vecs[i].pix}});
            apply();
            run_until_out(out_cnt + 1, 20, $sformatf("primary_%0d", i));
            chkw($sformatf("primary_%0d", i), s_pop_data, {16{vecs[i].gray}});
        end

        // Mixed line and first-output latency.
        for (int i = 0; i < 16; i++) line[32*i +: 32] = {8'h00, 8'(i), 8'(2*i), 8'(3*i)};
        tx_q.push_back(line);
        apply();
        s_acc = 0; n = 0;
        while (!s_acc && n < 10) begin step(); n++; end
        chk1("mixed_accepted", s_acc, 1'b1);
        lat = 0;
        do begin step(); lat++; end while (!s_vo && lat < 10);
        chki("mixed_latency", lat, 3);
        chkw("mixed_value", s_pop_data, model(line));

        // Backpressure: six lines offered, four credits.
        ready_lvl = 0; apply();
        obase = out_cnt; base = acc_cnt;
        for (int i = 0; i < 6; i++) tx_q.push_back(rand_line());
        apply();
        repeat (12) step();
        chki("bp_accepted", acc_cnt - base, 4);
        chk1("bp_ready_low", ready_in, 1'b0);
        ready_lvl = 1; apply();
        step();
        chk1("bp_first_pop", s_pop, 1'b1);
        chk1("bp_no_accept_with_pop", s_acc, 1'b0);
        step();
        chk1("bp_line5_accept", s_acc, 1'b1);
        run_until_out(obase + 6, 60, "bp_drain");

        // Streaming at full rate.
        for (int i = 0; i < 1000; i++) tx_q.push_back(rand_line());
        apply();
        tgt = out_cnt + 1000; n = 0; bubbles = 0; in_stalls = 0; first_acc = -1; first_out = -1;
        while (out_cnt < tgt && n < 1200) begin
            step();
            n++;
            if (s_acc && first_acc < 0) first_acc = cyc;
            if (holding) in_stalls++;
            if (s_pop && first_out < 0) first_out = cyc;
            else if (first_out >= 0 && !s_pop && out_cnt < tgt) bubbles++;
        end
        chki("stream_outputs", out_cnt, tgt);
        chki("stream_fill", first_out - first_acc, 3);
        chki("stream_bubbles", bubbles, 0);
        chki("stream_input_stalls", in_stalls, 0);

        // Random valid/ready toggling.
        rnd_valid = 1; rnd_ready = 1;
        for (int i = 0; i < 300; i++) tx_q.push_back(rand_line());
        apply();
        run_until_out(out_cnt + 300, 4000, "random");
        rnd_valid = 0; rnd_ready = 0; ready_lvl = 1; apply();
        repeat (4) step();
        chki("random_drained_queue", exp_q.size(), 0);
        chk1("random_busy_drained", busy, 1'b0);

        // Reset with two lines buffered and two in the pipeline.
        ready_lvl = 0; apply();
        base = acc_cnt; n = 0;
        for (int i = 0; i < 4; i++) tx_q.push_back(rand_line());
        apply();
        while (acc_cnt - base < 4 && n < 20) begin step(); n++; end
        chki("reset_fill_accepted", acc_cnt - base, 4);
        tx_q.delete(); valid_in = 1'b0; ready_lvl = 1; ready_out = 1'b1;
        rst = 1'b1;
        obase = out_cnt;
        step();
        rst = 1'b0;
        #1;
        chk1("post_reset_valid_out", valid_out, 1'b0);
        chk1("post_reset_busy", busy, 1'b0);
        chki("no_output_during_reset", out_cnt, obase);
        line = rand_line();
        tx_q.push_back(line);
        apply();
        run_until_out(out_cnt + 1, 20, "post_reset_first");
        chkw("post_reset_first_line", s_pop_data, model(line));
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
